// File: rtl/draw_sprite_pkg.sv
// Shared screen constants, movement bit indices and FSM state type for draw_sprite.
package draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOR_W  = 3;

    localparam int unsigned MV_UP = 0;
    localparam int unsigned MV_DN = 1;
    localparam int unsigned MV_LT = 2;
    localparam int unsigned MV_RT = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_FETCH,
        S_CAPTURE,
        S_FINISH,
        S_DONE
    } draw_state_t;

    // One axis of motion: step toward inc/dec, clamped to [0, lim]; opposing requests cancel.
    function automatic int unsigned step_axis(input int unsigned pos, input logic inc,
                                              input logic dec, input int unsigned lim,
                                              input int unsigned step);
        if (inc && !dec) begin
            return (pos + step > lim) ? lim : pos + step;
        end
        if (dec && !inc) begin
            return (pos >= step) ? pos - step : 0;
        end
        return pos;
    endfunction

endpackage

// File: rtl/draw_sprite_motion.sv
// Combinational sprite step: moves the top-left corner by STEP, clamped so the sprite stays on screen.
module sprite_motion
    import draw_pkg::*;
#(
    parameter int unsigned STEP  = 1,
    parameter int unsigned SPR_W = 8,
    parameter int unsigned SPR_H = 8
) (
    input  logic [X_W-1:0] pos_x,
    input  logic [Y_W-1:0] pos_y,
    input  logic [3:0]     movement,
    output logic [X_W-1:0] nxt_x,
    output logic [Y_W-1:0] nxt_y
);

    localparam int unsigned X_MAX = SCREEN_W - SPR_W;
    localparam int unsigned Y_MAX = SCREEN_H - SPR_H;

    always_comb begin
        nxt_x = X_W'(step_axis(32'(pos_x), movement[MV_RT], movement[MV_LT], X_MAX, STEP));
        nxt_y = Y_W'(step_axis(32'(pos_y), movement[MV_DN], movement[MV_UP], Y_MAX, STEP));
    end

endmodule

// File: rtl/draw_sprite.sv
// Sprite renderer: optional move, then one drawEn strobe per pixel with colour from a sync ROM.
// Define DRAW_SPRITE_TRANSPARENCY_EN to suppress strobes for ROM pixels equal to TRANSP in draw mode.
module draw_sprite
    import draw_pkg::*;
#(
    parameter int unsigned SPR_W    = 8,
    parameter int unsigned SPR_H    = 8,
    parameter int unsigned STEP     = 1,
    parameter int unsigned X_INIT   = 76,
    parameter int unsigned Y_INIT   = 29,
    parameter logic [2:0]  BG_COLOR = 3'b000,
    parameter logic [2:0]  TRANSP   = 3'b111
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              begin_draw,
    input  logic                              erase,
    input  logic [3:0]                        movement,
    output logic [$clog2(SPR_W*SPR_H)-1:0]    rom_addr,
    input  logic [COLOR_W-1:0]                rom_data,
    output logic [X_W-1:0]                    x,
    output logic [Y_W-1:0]                    y,
    output logic [COLOR_W-1:0]                color,
    output logic                              drawEn,
    output logic                              done,
    output logic [X_W-1:0]                    pos_x,
    output logic [Y_W-1:0]                    pos_y
);

    localparam int unsigned ADDR_W = $clog2(SPR_W * SPR_H);
    localparam int unsigned COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROW_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    draw_state_t        state_q, state_d;
    logic               req_q, req_d;
    logic               req_erase_q, req_erase_d;
    logic [3:0]         req_mv_q, req_mv_d;
    logic               erase_q, erase_d;
    logic [3:0]         mv_q, mv_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [X_W-1:0]     pos_x_q, pos_x_d, x_q, x_d, nxt_x;
    logic [Y_W-1:0]     pos_y_q, pos_y_d, y_q, y_d, nxt_y;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               draw_en_q, draw_en_d;
    logic               done_q, done_d;
    logic               last_col, last_pix, skip_c;

    sprite_motion #(.STEP(STEP), .SPR_W(SPR_W), .SPR_H(SPR_H)) u_motion (
        .pos_x    (pos_x_q),
        .pos_y    (pos_y_q),
        .movement (mv_q),
        .nxt_x    (nxt_x),
        .nxt_y    (nxt_y)
    );

    assign last_col = (col_q == COL_W'(SPR_W - 1));
    assign last_pix = last_col && (row_q == ROW_W'(SPR_H - 1));
    assign rom_addr = ADDR_W'(row_q) * ADDR_W'(SPR_W) + ADDR_W'(col_q);

`ifdef DRAW_SPRITE_TRANSPARENCY_EN
    assign skip_c = !erase_q && (rom_data == TRANSP);
`else
    assign skip_c = 1'b0 && (rom_data == TRANSP);
`endif

    // Request is registered, so the frame starts the cycle after begin_draw is first sampled.
    assign req_d       = begin_draw;
    assign req_erase_d = erase;
    assign req_mv_d    = movement;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req_q) state_d = S_MOVE;
            S_MOVE:    state_d = S_FETCH;
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = last_pix ? S_FINISH : S_FETCH;
            S_FINISH:  state_d = S_DONE;
            S_DONE:    if (!begin_draw) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        erase_d   = erase_q;
        mv_d      = mv_q;
        col_d     = col_q;
        row_d     = row_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        draw_en_d = 1'b0;
        done_d    = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (req_q) begin
                    erase_d = req_erase_q;
                    mv_d    = req_mv_q;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_MOVE: begin
                if (!erase_q) begin
                    pos_x_d = nxt_x;
                    pos_y_d = nxt_y;
                end
            end
            S_CAPTURE: begin
                x_d       = pos_x_q + X_W'(col_q);
                y_d       = pos_y_q + Y_W'(row_q);
                color_d   = erase_q ? BG_COLOR : rom_data;
                draw_en_d = !skip_c;
                if (last_col) begin
                    col_d = '0;
                    row_d = last_pix ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q       <= 1'b0;
            req_erase_q <= 1'b0;
            req_mv_q    <= '0;
            erase_q     <= 1'b0;
            mv_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pos_x_q     <= X_W'(X_INIT);
            pos_y_q     <= Y_W'(Y_INIT);
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            draw_en_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            req_q       <= req_d;
            req_erase_q <= req_erase_d;
            req_mv_q    <= req_mv_d;
            erase_q     <= erase_d;
            mv_q        <= mv_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            x_q         <= x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            draw_en_q   <= draw_en_d;
            done_q      <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign color  = color_q;
    assign drawEn = draw_en_q;
    assign done   = done_q;
    assign pos_x  = pos_x_q;
    assign pos_y  = pos_y_q;

endmodule

// File: tb/tb_draw_sprite.sv
// Randomized bench for draw_sprite: a pixel-list model predicts every strobe, address and done cycle.
module tb_draw_sprite;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;
    localparam int STEP_TB = 1;

    logic       clk = 1'b0;
    logic       reset, begin_draw, erase;
    logic [3:0] movement;
    logic [5:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] x, pos_x;
    logic [6:0] y, pos_y;
    logic [2:0] color;
    logic       drawEn, done;

    logic [7:0] m4_x, m4_nx;
    logic [6:0] m4_y, m4_ny;
    logic [3:0] m4_mv;

    logic [2:0] rom_mem [N];
    int n_cmp = 0;
    int n_bad = 0;
    int mod_x = 76;
    int mod_y = 29;
    int strobes, first_x, first_y, last_x, last_y, done_edge;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    draw_sprite dut (
        .clk        (clk),
        .reset      (reset),
        .begin_draw (begin_draw),
        .erase      (erase),
        .movement   (movement),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .x          (x),
        .y          (y),
        .color      (color),
        .drawEn     (drawEn),
        .done       (done),
        .pos_x      (pos_x),
        .pos_y      (pos_y)
    );

    sprite_motion #(.STEP(4), .SPR_W(8), .SPR_H(8)) u_m4 (
        .pos_x    (m4_x),
        .pos_y    (m4_y),
        .movement (m4_mv),
        .nxt_x    (m4_nx),
        .nxt_y    (m4_ny)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_move(input logic [3:0] mv);
        int dx, dy;
        dx = int'(mv[3]) - int'(mv[2]);
        dy = int'(mv[1]) - int'(mv[0]);
        mod_x = clampi(mod_x + dx * STEP_TB, 0, 160 - W);
        mod_y = clampi(mod_y + dy * STEP_TB, 0, 120 - H);
    endtask

    function automatic logic exp_skip(input int k, input logic er);
`ifdef DRAW_SPRITE_TRANSPARENCY_EN
        return !er && (rom_mem[k] == 3'b111);
`else
        return 1'b0 && er && (k < 0);
`endif
    endfunction

    function automatic void fill_rom(input int maxv);
        for (int i = 0; i < N; i++) rom_mem[i] = 3'($urandom_range(0, maxv));
    endfunction

    // Runs one frame; caller is just after a posedge with the DUT idle. abort_at >= 0 resets mid-frame.
    task automatic run_frame(input logic er, input logic [3:0] mv, input int drop_at, input int abort_at);
        int k;
        logic en;
        strobes   = 0;
        done_edge = -1;
        if (!er) model_move(mv);
        begin_draw = 1'b1;
        erase      = er;
        movement   = mv;
        for (int n = 0; n <= 2 * N + 3; n++) begin
            @(posedge clk);
            #1;
            k  = (n - 4) / 2;
            en = (n >= 4) && (n % 2 == 0) && (k < N);
            if (en) en = !exp_skip(k, er);
            chk("drawEn", 32'(drawEn), 32'(en));
            if (en) begin
                chk("x", 32'(x), 32'(mod_x + k % W));
                chk("y", 32'(y), 32'(mod_y + k / W));
                chk("color", 32'(color), er ? 32'd0 : 32'(rom_mem[k]));
                if (strobes == 0) begin
                    first_x = int'(x);
                    first_y = int'(y);
                end
                last_x = int'(x);
                last_y = int'(y);
                strobes++;
            end
            if (n >= 2 && n % 2 == 0 && (n - 2) / 2 < N)
                chk("rom_addr", 32'(rom_addr), 32'((n - 2) / 2));
            chk("done", 32'(done), 32'(n >= 2 * N + 3));
            if (done && done_edge < 0) done_edge = n;
            if (n == abort_at) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_drawEn", 32'(drawEn), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_pos_x", 32'(pos_x), 32'd76);
                chk("rst_pos_y", 32'(pos_y), 32'd29);
                chk("rst_addr", 32'(rom_addr), 32'd0);
                @(negedge clk);
                reset      = 1'b0;
                begin_draw = 1'b0;
                mod_x      = 76;
                mod_y      = 29;
                return;
            end
            if (n == drop_at) begin_draw = 1'b0;
        end
        chk("pos_x", 32'(pos_x), 32'(mod_x));
        chk("pos_y", 32'(pos_y), 32'(mod_y));
        if (begin_draw) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                chk("done_hold", 32'(done), 32'd1);
            end
        end
        begin_draw = 1'b0;
        @(posedge clk);
        #1;
        chk("done_clear", 32'(done), 32'd0);
        chk("drawEn_idle", 32'(drawEn), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        begin_draw = 1'b0;
        erase      = 1'b0;
        movement   = 4'd0;
        m4_x = 8'd0;
        m4_y = 7'd0;
        m4_mv = 4'd0;
        fill_rom(7);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x", 32'(x), 32'd0);
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_color", 32'(color), 32'd0);
        chk("reset_drawEn", 32'(drawEn), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_addr", 32'(rom_addr), 32'd0);
        chk("reset_pos_x", 32'(pos_x), 32'd76);
        chk("reset_pos_y", 32'(pos_y), 32'd29);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain draw, no motion
        run_frame(1'b0, 4'b0000, -1, -1);
        chk("t1_strobes", 32'(strobes), 32'd64);
        chk("t1_first_x", 32'(first_x), 32'd76);
        chk("t1_first_y", 32'(first_y), 32'd29);
        chk("t1_last_x", 32'(last_x), 32'd83);
        chk("t1_last_y", 32'(last_y), 32'd36);
        chk("t1_done_edge", 32'(done_edge), 32'd131);

        // Erase ignores movement
        run_frame(1'b1, 4'b1000, -1, -1);
        chk("t4_pos_x", 32'(pos_x), 32'd76);
        chk("t4_pos_y", 32'(pos_y), 32'd29);
        chk("t4_strobes", 32'(strobes), 32'd64);

        // Transparent ROM word 5
        fill_rom(6);
        rom_mem[5] = 3'b111;
        run_frame(1'b0, 4'b0000, -1, -1);
`ifdef DRAW_SPRITE_TRANSPARENCY_EN
        chk("t5_strobes", 32'(strobes), 32'd63);
`else
        chk("t5_strobes", 32'(strobes), 32'd64);
`endif
        chk("t5_done_edge", 32'(done_edge), 32'd131);

        // Reset during pixel 20, then a clean frame from addr 0
        fill_rom(7);
        run_frame(1'b0, 4'b1010, -1, 44);
        run_frame(1'b0, 4'b0000, -1, -1);
        chk("t6_strobes", 32'(strobes), 32'd64);

        repeat (20) begin
            fill_rom(7);
            run_frame(1'($urandom_range(0, 3) == 0), 4'($urandom),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 130)) : -1, -1);
        end

        // Right-edge clamp
        for (int i = 0; i < 200 && mod_x != 151; i++)
            run_frame(1'b0, (mod_x < 151) ? 4'b1000 : 4'b0100, -1, -1);
        chk("t2_pos_151", 32'(pos_x), 32'd151);
        run_frame(1'b0, 4'b1000, -1, -1);
        chk("t2_pos_152", 32'(pos_x), 32'd152);
        run_frame(1'b0, 4'b1000, -1, -1);
        chk("t2_pos_hold", 32'(pos_x), 32'd152);

        m4_x = 8'd150; m4_y = 7'd110; m4_mv = 4'b1010;
        #1;
        chk("step4_right", 32'(m4_nx), 32'd152);
        chk("step4_down", 32'(m4_ny), 32'd112);
        m4_x = 8'd2; m4_y = 7'd3; m4_mv = 4'b0101;
        #1;
        chk("step4_left", 32'(m4_nx), 32'd0);
        chk("step4_up", 32'(m4_ny), 32'd0);

        // Top-edge clamp and opposing bits
        for (int i = 0; i < 200 && mod_y != 0; i++)
            run_frame(1'b0, 4'b0001, -1, -1);
        run_frame(1'b0, 4'b0001, -1, -1);
        chk("t3_pos_y0", 32'(pos_y), 32'd0);
        run_frame(1'b0, 4'b0011, -1, -1);
        chk("t3_opp_x", 32'(pos_x), 32'd152);
        chk("t3_opp_y", 32'(pos_y), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
